hil_echo_responder: RTL and testbench
=====================================

# hil_echo_responder

- Hardware-side transaction endpoint for the hilihase hardware-in-the-loop harness.
- Consumes the request stream that the DPI-C bridge testbench produces (echo, double, close calls) and returns tagged responses through a small response FIFO.
- The bridge forwards each response back to the C/JNI side.

## Interface

Parameters:
- DATA_W, 32, request/response data width
- TAG_W, 4, transaction tag width
- DEPTH, 4, response FIFO entries (≥2, any integer)

Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_op  in  2  0=ECHO, 1=DOUBLE, 2=CLOSE, 3=reserved
- req_tag  in  TAG_W  transaction tag, returned unchanged
- req_data  in  DATA_W  request operand
- rsp_valid  out  1  response at FIFO head
- rsp_ready  in  1  consumer takes response
- rsp_tag  out  TAG_W  tag of head response
- rsp_data  out  DATA_W  result
- rsp_status  out  2  0=OK, 1=BAD_OP, 2=CLOSED
- closed  out  1  session closed flag
- pending  out  $clog2(DEPTH+1)  responses held in FIFO

## Operation

Handshake:
- Request is accepted on a cycle with req_valid && req_ready.
- req_ready = (pending != DEPTH).
- req_ready does not consider a same-cycle pop: when the FIFO is full, no request is accepted even if rsp_ready=1.

Each accepted request produces exactly one response entry, pushed in the same cycle.

State machine:
- Two states, OPEN and CLOSED.
- Reset → OPEN.
- Accepting a CLOSE request in OPEN → CLOSED.
- CLOSED is exited only by reset.

Response contents while OPEN:
- ECHO: data = req_data, status OK.
- DOUBLE: data = req_data << 1, truncated to DATA_W (MSB discarded, no saturation), status OK.
- CLOSE: data = 0, status OK.
- op 3: data = 0, status BAD_OP. The state does not change.

Response contents while CLOSED:
- Every op, including CLOSE and op 3: data = 0, status CLOSED.

closed = (state == CLOSED).

FIFO:
- Circular buffer with read and write pointers.
- Each pointer wraps from DEPTH-1 to 0.
- pending tracks occupancy.
- Push and pop in the same cycle leaves pending unchanged.
- rsp_valid = (pending != 0).
- rsp_tag, rsp_data and rsp_status are the head entry.
- Responses leave in strict acceptance order.

Reset (including mid-transaction):
- FIFO contents discarded, pointers = 0, pending = 0, state = OPEN.
- Any request presented during the reset cycle is dropped.

## Timing

Reset values (outputs, the cycle after rst_n sampled low):
- rsp_valid 0
- req_ready 1
- closed 0
- pending 0
- rsp_tag, rsp_data and rsp_status are 0 while rsp_valid=0

Latency:
- A request accepted in cycle N gives rsp_valid=1 in cycle N+1, provided the FIFO was empty.
- Otherwise the response appears behind the older entries.

Output stability:
- While rsp_valid && !rsp_ready, rsp_tag, rsp_data and rsp_status hold stable.

Timing of closed:
- closed rises in cycle N+1 after a CLOSE is accepted in cycle N.
- A request accepted in cycle N+1 already gets status CLOSED.

Throughput:
- With rsp_ready held high, one request per cycle is sustained and pending stays ≤1.

Occupancy:
- pending is registered.
- It changes one cycle after a push or pop.

## Test plan

- **ECHO.** ECHO tag=1 data=42, rsp_ready=1 → next cycle: rsp_valid=1, tag=1, data=42, status OK; pending=1 then 0.
- **DOUBLE.**
  - DOUBLE data=84 → data=168, status OK.
  - DOUBLE data=0x80000001 → data=0x00000002, status OK.
- **Full and drain.**
  - Hold rsp_ready=0 and issue ECHO tags 0..4 back-to-back.
  - Tags 0..3 are accepted; req_ready=0 once pending=4; tag 4 stalls.
  - Raise rsp_ready → responses for tags 0,1,2,3 in order, then tag 4 is accepted.
  - Pointer wrap is exercised over a second fill.
- **Close.**
  - CLOSE tag=2 → status OK, data 0, closed=1 next cycle.
  - Then ECHO data=7 → status CLOSED, data 0.
  - Then CLOSE again → status CLOSED.
- **Reserved op.** op=3 data=5 → status BAD_OP, data 0, closed stays 0; a following ECHO 9 returns 9 OK.
- **Reset mid-fill.** Accept 3 requests with rsp_ready=0, assert rst_n=0 for one cycle → pending=0, rsp_valid=0, closed=0, req_ready=1; the next ECHO 42 returns 42 with latency 1.

Source files
------------

// File: rtl/hil_echo_responder.sv
// HIL echo endpoint: request to tagged response, 1-cycle latency into an empty FIFO.
// req_ready drops whenever the response FIFO is full, even on a cycle that pops.
module hil_echo_responder #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [TAG_W-1:0]           req_tag,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [1:0]                 rsp_status,
    output logic                       closed,
    output logic [$clog2(DEPTH+1)-1:0] pending
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] OP_ECHO   = 2'd0;
    localparam logic [1:0] OP_DOUBLE = 2'd1;
    localparam logic [1:0] OP_CLOSE  = 2'd2;

    localparam logic [1:0] ST_OK     = 2'd0;
    localparam logic [1:0] ST_BADOP  = 2'd1;
    localparam logic [1:0] ST_CLOSED = 2'd2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        status;
    } rsp_t;

    typedef enum logic {
        S_OPEN   = 1'b0,
        S_CLOSED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    rsp_t               mem [DEPTH];
    rsp_t               push_ent;
    rsp_t               head_ent;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               accept, pop;

    assign req_ready = (count != CNT_W'(DEPTH));
    assign rsp_valid = (count != '0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign pending   = count;
    assign closed    = (state_q == S_CLOSED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        push_ent.tag    = req_tag;
        push_ent.data   = '0;
        push_ent.status = ST_CLOSED;
        if (state_q == S_OPEN) begin
            push_ent.status = ST_OK;
            case (req_op)
                OP_ECHO:   push_ent.data = req_data;
                OP_DOUBLE: push_ent.data = {req_data[DATA_W-2:0], 1'b0};
                OP_CLOSE: begin
                    if (accept) begin
                        state_d = S_CLOSED;
                    end
                end
                default:   push_ent.status = ST_BADOP;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        head_ent = '0;
        if (rsp_valid) begin
            head_ent = mem[rd_ptr];
        end
    end

    assign rsp_tag    = head_ent.tag;
    assign rsp_data   = head_ent.data;
    assign rsp_status = head_ent.status;

endmodule

// File: tb/tb_hil_echo_responder.sv
// Bench for hil_echo_responder: queue-based response model checked every cycle, plus directed literals.
module tb_hil_echo_responder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [3:0]  req_tag = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        closed;
    logic [2:0]  pending;

    int n_tot = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hil_echo_responder #(.DATA_W(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .closed(closed), .pending(pending)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: a queue of expected responses and a session flag.
    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [1:0]  status;
    } ent_t;

    ent_t m_q[$];
    bit   m_closed = 1'b0;
    bit   m_live = 1'b0;

    always @(posedge clk) begin
        bit   acc, pp;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_closed = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            acc = req_valid && (m_q.size() != DEPTH);
            pp  = rsp_ready && (m_q.size() != 0);
            if (pp) void'(m_q.pop_front());
            if (acc) begin
                e.tag = req_tag;
                e.data = 32'd0;
                e.status = 2'd0;
                if (m_closed) e.status = 2'd2;
                else if (req_op == 2'd0) e.data = req_data;
                else if (req_op == 2'd1) e.data = req_data * 32'd2;
                else if (req_op == 2'd3) e.status = 2'd1;
                m_q.push_back(e);
                if (!m_closed && req_op == 2'd2) m_closed = 1'b1;
            end
        end
    end

    logic [3:0] popped[$];

    always @(negedge clk) begin
        if (m_live) begin
            chk("rsp_valid", rsp_valid, m_q.size() != 0);
            chk("pending", pending, m_q.size());
            chk("req_ready", req_ready, m_q.size() != DEPTH);
            chk("closed", closed, m_closed);
            if (m_q.size() != 0) begin
                chk("rsp_tag", rsp_tag, m_q[0].tag);
                chk("rsp_data", rsp_data, m_q[0].data);
                chk("rsp_status", rsp_status, m_q[0].status);
                if (rsp_ready) popped.push_back(rsp_tag);
            end else begin
                chk("idle_fields", {rsp_tag, rsp_data, rsp_status}, 38'd0);
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string nm);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready;
            to_drive();
            n++;
        end
        if (!acc) begin
            n_tot++;
            $display("FAIL %s: request not accepted, got timeout, expected accept", nm);
        end
        req_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] tag, input logic [31:0] data);
        req_op = op;
        req_tag = tag;
        req_data = data;
        req_valid = 1'b1;
        wait_accept("send");
    endtask

    task automatic chk_popped(input string nm, input int first, input int cnt);
        chk({nm, "_count"}, popped.size(), cnt);
        for (int i = 0; i < cnt && i < popped.size(); i++)
            chk(nm, popped[i], first + i);
    endtask

    initial begin
        to_drive();
        to_drive();
        @(negedge clk);
        chk("reset_valid", rsp_valid, 1'b0);
        chk("reset_ready", req_ready, 1'b1);
        chk("reset_pending", pending, 3'd0);
        rst_n = 1'b1;
        to_drive();

        // Echo
        rsp_ready = 1'b1;
        send(2'd0, 4'd1, 32'd42);
        @(negedge clk);
        chk("echo_valid", rsp_valid, 1'b1);
        chk("echo_tag", rsp_tag, 4'd1);
        chk("echo_data", rsp_data, 32'd42);
        chk("echo_status", rsp_status, 2'd0);
        chk("echo_pend1", pending, 3'd1);
        to_drive();
        @(negedge clk);
        chk("echo_pend0", pending, 3'd0);
        to_drive();

        // Double, including MSB drop
        send(2'd1, 4'd3, 32'd84);
        @(negedge clk);
        chk("dbl_data", rsp_data, 32'd168);
        to_drive();
        send(2'd1, 4'd4, 32'h8000_0001);
        @(negedge clk);
        chk("dbl_wrap", rsp_data, 32'h0000_0002);
        chk("dbl_status", rsp_status, 2'd0);
        to_drive();

        // Reserved op
        send(2'd3, 4'd5, 32'd5);
        @(negedge clk);
        chk("bad_status", rsp_status, 2'd1);
        chk("bad_data", rsp_data, 32'd0);
        chk("bad_closed", closed, 1'b0);
        to_drive();
        send(2'd0, 4'd6, 32'd9);
        @(negedge clk);
        chk("after_bad_data", rsp_data, 32'd9);
        chk("after_bad_status", rsp_status, 2'd0);
        to_drive();
        to_drive();

        // Fill, stall, drain, then a second fill across the pointer wrap
        rsp_ready = 1'b0;
        popped.delete();
        for (int t = 0; t < 4; t++) send(2'd0, 4'(t), 32'(100 + t));
        @(negedge clk);
        chk("full_pending", pending, 3'd4);
        chk("full_ready", req_ready, 1'b0);
        to_drive();
        req_op = 2'd0; req_tag = 4'd4; req_data = 32'd104; req_valid = 1'b1;
        to_drive();
        to_drive();
        @(negedge clk);
        chk("stall_pending", pending, 3'd4);
        to_drive();
        rsp_ready = 1'b1;
        wait_accept("tag4");
        repeat (6) to_drive();
        chk_popped("drain1", 0, 5);

        rsp_ready = 1'b0;
        popped.delete();
        for (int t = 5; t < 9; t++) send(2'd0, 4'(t), 32'(200 + t));
        @(negedge clk);
        chk("refill_pending", pending, 3'd4);
        to_drive();
        rsp_ready = 1'b1;
        repeat (6) to_drive();
        chk_popped("drain2", 5, 4);

        // Back-to-back throughput
        for (int t = 0; t < 5; t++) send(2'd1, 4'(t), 32'(t * 3));
        repeat (2) to_drive();

        // Close
        send(2'd2, 4'd2, 32'd77);
        @(negedge clk);
        chk("close_status", rsp_status, 2'd0);
        chk("close_data", rsp_data, 32'd0);
        chk("close_tag", rsp_tag, 4'd2);
        chk("close_flag", closed, 1'b1);
        to_drive();
        send(2'd0, 4'd7, 32'd7);
        @(negedge clk);
        chk("closed_echo_status", rsp_status, 2'd2);
        chk("closed_echo_data", rsp_data, 32'd0);
        to_drive();
        send(2'd2, 4'd8, 32'd1);
        @(negedge clk);
        chk("closed_close_status", rsp_status, 2'd2);
        to_drive();

        // Reset mid-fill with a request present during reset
        rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) send(2'd0, 4'(t), 32'(t));
        rst_n = 1'b0;
        req_op = 2'd0; req_tag = 4'd15; req_data = 32'd99; req_valid = 1'b1;
        to_drive();
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pending", pending, 3'd0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_closed", closed, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        to_drive();
        rsp_ready = 1'b1;
        send(2'd0, 4'd9, 32'd42);
        @(negedge clk);
        chk("post_rst_valid", rsp_valid, 1'b1);
        chk("post_rst_data", rsp_data, 32'd42);
        to_drive();
        to_drive();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
